trdb_packet_unpacker: RTL and testbench



---
 rtl/trdb_packet_unpacker.sv | 179 +++++++++++++++++
 tb/tb_trdb_packet_unpacker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_unpacker.sv
// Reassembles length-prefixed trace packets from a non-stallable word stream
// and queues complete packets behind a valid/ready output port.
module trdb_packet_unpacker #(
  parameter int XLEN       = 32,
  parameter int LENBITS    = 7,
  parameter int MAX_WORDS  = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [XLEN-1:0]             packet_word_i,
  input  logic                        packet_word_valid_i,
  output logic [MAX_WORDS*XLEN-1:0]   packet_o,
  output logic [LENBITS-1:0]          packet_len_o,
  output logic                        packet_valid_o,
  input  logic                        packet_ready_i,
  output logic                        overflow_o,
  output logic                        len_error_o
);

  // state     | meaning
  // S_IDLE    | next valid word is a header
  // S_COLLECT | header accepted, gathering the remaining payload words

  localparam int TOTAL = MAX_WORDS * XLEN;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [LENBITS:0] NW_ONE = 1;
  localparam logic [LENBITS:0] NW_X   = XLEN;
  localparam logic [LENBITS:0] NW_XM1 = XLEN - 1;

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t               r_state, w_state_next;
  logic [TOTAL-1:0]     r_data;
  logic [LENBITS-1:0]   r_len;
  logic [LENBITS:0]     r_nwords;
  logic [LENBITS:0]     r_cnt;
  logic                 r_len_err;
  logic                 r_overflow;

  logic [TOTAL-1:0]     r_mem_data [FIFO_DEPTH];
  logic [LENBITS-1:0]   r_mem_len  [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [QW-1:0]        r_count;

  logic [LENBITS-1:0]   w_hdr_len;
  logic [LENBITS:0]     w_hdr_nwords;
  logic                 w_hdr_bad;
  logic                 w_accept_hdr, w_store, w_complete, w_hdr_err;
  logic [LENBITS-1:0]   w_cur_len;
  logic [TOTAL-1:0]     w_data_next, w_mask, w_push_data;
  logic                 w_empty, w_full, w_pop, w_push, w_drop;

  assign w_hdr_len    = packet_word_i[LENBITS-1:0];
  assign w_hdr_bad    = (w_hdr_len == '0) || (int'(w_hdr_len) > TOTAL);
  // Widened by one bit so len + XLEN-1 cannot wrap.
  assign w_hdr_nwords = ({1'b0, w_hdr_len} + NW_XM1) / NW_X;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept_hdr = 1'b0;
    w_store      = 1'b0;
    w_complete   = 1'b0;
    w_hdr_err    = 1'b0;
    w_cur_len    = r_len;
    case (r_state)
      S_IDLE: begin
        if (packet_word_valid_i) begin
          if (w_hdr_bad) begin
            w_hdr_err = 1'b1;
          end else begin
            w_accept_hdr = 1'b1;
            w_cur_len    = w_hdr_len;
            if (w_hdr_nwords == NW_ONE) w_complete   = 1'b1;
            else                        w_state_next = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (packet_word_valid_i) begin
          w_store = 1'b1;
          if (r_cnt + NW_ONE == r_nwords) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_next = r_data;
    if (w_accept_hdr) begin
      w_data_next            = '0;
      w_data_next[XLEN-1:0] = packet_word_i;
    end else if (w_store) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (r_cnt == (LENBITS+1)'(k)) w_data_next[k*XLEN +: XLEN] = packet_word_i;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < TOTAL; i++) w_mask[i] = (i < int'(w_cur_len));
  end

  assign w_push_data = w_data_next & w_mask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data    <= '0;
      r_len     <= '0;
      r_nwords  <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_hdr_err;
      if (w_accept_hdr) begin
        r_data   <= w_data_next;
        r_len    <= w_hdr_len;
        r_nwords <= w_hdr_nwords;
        r_cnt    <= NW_ONE;
      end else if (w_store) begin
        r_data <= w_data_next;
        r_cnt  <= r_cnt + NW_ONE;
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == QW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && packet_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_complete && (!w_full || w_pop);
  assign w_drop  = w_complete && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_len[i]  <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_len[r_wr_ptr]  <= w_cur_len;
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + QW'(1);
      else if (!w_push && w_pop) r_count <= r_count - QW'(1);
      if (w_drop)       r_overflow <= 1'b1;
      else if (clear_i) r_overflow <= 1'b0;
    end
  end

  assign packet_valid_o = !w_empty;
  assign packet_o       = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign packet_len_o   = w_empty ? '0 : r_mem_len[r_rd_ptr];
  assign overflow_o     = r_overflow;
  assign len_error_o    = r_len_err;

endmodule

// File: tb/tb_trdb_packet_unpacker.sv
// Self-checking bench: directed scenarios plus random traffic against a
// packet-level queue model of the unpacker.
module tb_trdb_packet_unpacker;

  localparam int XLEN = 32, LENBITS = 7, MAX_WORDS = 3, DEPTH = 2;
  localparam int TOTAL = XLEN * MAX_WORDS;

  logic              clk_i = 1'b0;
  logic              rst_i, clear_i, packet_word_valid_i, packet_ready_i;
  logic [XLEN-1:0]   packet_word_i;
  logic [TOTAL-1:0]  packet_o;
  logic [LENBITS-1:0] packet_len_o;
  logic              packet_valid_o, overflow_o, len_error_o;

  trdb_packet_unpacker #(
    .XLEN(XLEN), .LENBITS(LENBITS), .MAX_WORDS(MAX_WORDS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .packet_word_i(packet_word_i), .packet_word_valid_i(packet_word_valid_i),
    .packet_o(packet_o), .packet_len_o(packet_len_o),
    .packet_valid_o(packet_valid_o), .packet_ready_i(packet_ready_i),
    .overflow_o(overflow_o), .len_error_o(len_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [TOTAL-1:0]   d;
    logic [LENBITS-1:0] l;
  } pkt_t;

  pkt_t             m_q[$];
  bit               m_in_pkt, m_ovf, m_lerr;
  int               m_len, m_need, m_got;
  logic [TOTAL-1:0] m_buf;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus entry: {valid, ready, clear, rst, word}
  function automatic logic [35:0] st(input bit v, input bit r, input bit c,
                                     input bit rs, input logic [31:0] w);
    return {v, r, c, rs, w};
  endfunction

  task automatic model_cycle(input logic [35:0] s);
    bit               complete;
    logic [TOTAL:0]   one;
    logic [TOTAL:0]   mask;
    pkt_t             p;
    if (s[32]) begin
      m_q.delete();
      m_in_pkt = 0; m_ovf = 0; m_lerr = 0; m_got = 0;
      return;
    end
    m_lerr   = 0;
    complete = 0;
    if (s[35]) begin
      if (!m_in_pkt) begin
        m_len = int'(s[LENBITS-1:0]);
        if (m_len == 0 || m_len > TOTAL) begin
          m_lerr = 1;
        end else begin
          m_need = (m_len + XLEN - 1) / XLEN;
          m_buf  = '0;
          m_buf[XLEN-1:0] = s[31:0];
          m_got  = 1;
          if (m_need == 1) complete = 1;
          else m_in_pkt = 1;
        end
      end else begin
        m_buf[m_got*XLEN +: XLEN] = s[31:0];
        m_got++;
        if (m_got == m_need) begin
          complete = 1;
          m_in_pkt = 0;
        end
      end
    end
    if (s[34] && m_q.size() > 0) void'(m_q.pop_front());
    if (s[33]) m_ovf = 0;
    if (complete) begin
      one  = 1;
      mask = (one << m_len) - one;
      p.d  = m_buf & mask[TOTAL-1:0];
      p.l  = LENBITS'(m_len);
      if (m_q.size() < DEPTH) m_q.push_back(p);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic [35:0] s);
    packet_word_valid_i = s[35];
    packet_ready_i      = s[34];
    clear_i             = s[33];
    rst_i               = s[32];
    packet_word_i       = s[31:0];
    model_cycle(s);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [TOTAL+LENBITS+2:0] observed();
    return {packet_valid_o,
            packet_valid_o ? packet_len_o : {LENBITS{1'b0}},
            packet_valid_o ? packet_o : {TOTAL{1'b0}},
            overflow_o, len_error_o};
  endfunction

  function automatic logic [TOTAL+LENBITS+2:0] expected();
    pkt_t h;
    h = '0;
    if (m_q.size() > 0) h = m_q[0];
    return {m_q.size() > 0, h.l, h.d, m_ovf, m_lerr};
  endfunction

  task automatic test_reset();
    step(st(0, 0, 0, 1, 32'h0));
    step(st(0, 0, 0, 1, 32'h0));
    n_checks++;
    if ({packet_valid_o, packet_o, packet_len_o, overflow_o, len_error_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got valid=%b pkt=%h len=%0d ovf=%b lerr=%b required all 0",
               packet_valid_o, packet_o, packet_len_o, overflow_o, len_error_o);
    end
  endtask

  task automatic test_single();
    logic [35:0] tbl [2];
    tbl = '{st(1, 1, 0, 0, 32'hABCDE014), st(0, 1, 0, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL single_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i == 0) begin
        n_checks++;
        if (packet_valid_o !== 1'b1 || packet_len_o !== 7'd20 || packet_o !== 96'h000DE014) begin
          n_fail++;
          $display("FAIL single_word got valid=%b len=%0d pkt=%h required 1/20/000DE014",
                   packet_valid_o, packet_len_o, packet_o);
        end
      end
    end
  endtask

  task automatic test_multi_word();
    logic [35:0] tbl [7];
    tbl = '{st(1, 0, 0, 0, 32'h12345646), st(0, 0, 0, 0, 32'h0), st(1, 0, 0, 0, 32'hFFFFFFFF),
            st(0, 0, 0, 0, 32'h0), st(0, 0, 0, 0, 32'h0), st(1, 0, 0, 0, 32'h000000FF),
            st(0, 1, 0, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL multi_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i == 4) begin
        n_checks++;
        if (packet_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL multi_early_valid got=%b required=0", packet_valid_o);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (packet_valid_o !== 1'b1 || packet_len_o !== 7'd70 ||
            packet_o !== {32'h0000003F, 32'hFFFFFFFF, 32'h12345646}) begin
          n_fail++;
          $display("FAIL multi_word got valid=%b len=%0d pkt=%h required 1/70/0000003FFFFFFFFF12345646",
                   packet_valid_o, packet_len_o, packet_o);
        end
      end
    end
  endtask

  task automatic test_len_error();
    logic [35:0] tbl [4];
    tbl = '{st(1, 0, 0, 0, 32'h00000000), st(1, 0, 0, 0, 32'h0000007F),
            st(1, 0, 0, 0, 32'h00000008), st(0, 1, 0, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL lenerr_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i < 2) begin
        n_checks++;
        if (len_error_o !== 1'b1 || packet_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL len_error_pulse step=%0d got lerr=%b valid=%b required 1/0",
                   i, len_error_o, packet_valid_o);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (len_error_o !== 1'b0 || packet_o !== 96'h8 || packet_len_o !== 7'd8) begin
          n_fail++;
          $display("FAIL len_error_recover got lerr=%b pkt=%h len=%0d required 0/8/8",
                   len_error_o, packet_o, packet_len_o);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [35:0] tbl [6];
    tbl = '{st(1, 0, 0, 0, 32'h11), st(1, 0, 0, 0, 32'h12), st(1, 0, 1, 0, 32'h13),
            st(0, 1, 0, 0, 32'h0), st(0, 1, 0, 0, 32'h0), st(0, 0, 1, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL overflow_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i == 2) begin
        n_checks++;
        if (overflow_o !== 1'b1 || packet_o !== 96'h11) begin
          n_fail++;
          $display("FAIL overflow_set got ovf=%b head=%h required 1/11", overflow_o, packet_o);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (packet_valid_o !== 1'b1 || packet_o !== 96'h12) begin
          n_fail++;
          $display("FAIL overflow_second got valid=%b head=%h required 1/12", packet_valid_o, packet_o);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (overflow_o !== 1'b0 || packet_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow_clear got ovf=%b valid=%b required 0/0", overflow_o, packet_valid_o);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [35:0] tbl [5];
    tbl = '{st(1, 0, 0, 0, 32'h14), st(1, 0, 0, 0, 32'h15), st(1, 1, 0, 0, 32'h16),
            st(0, 1, 0, 0, 32'h0), st(0, 1, 0, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL pushpop_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i == 3) begin
        n_checks++;
        if (overflow_o !== 1'b0 || packet_o !== 96'h16 || packet_len_o !== 7'd22) begin
          n_fail++;
          $display("FAIL push_pop_full got ovf=%b head=%h len=%0d required 0/16/22",
                   overflow_o, packet_o, packet_len_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [35:0] tbl [4];
    tbl = '{st(1, 0, 0, 0, 32'h12345646), st(0, 0, 0, 1, 32'h0),
            st(1, 0, 0, 0, 32'h00000010), st(0, 1, 0, 0, 32'h0)};
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL rstmid_model step=%0d got=%h required=%h", i, observed(), expected());
      end
      if (i == 2) begin
        n_checks++;
        if (packet_valid_o !== 1'b1 || packet_o !== 96'h10 || packet_len_o !== 7'd16) begin
          n_fail++;
          $display("FAIL reset_mid_packet got valid=%b pkt=%h len=%0d required 1/10/16",
                   packet_valid_o, packet_o, packet_len_o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    bit v, r, c, rs;
    for (int i = 0; i < 800; i++) begin
      w      = $urandom();
      w[6:0] = 7'($urandom_range(0, 104));
      v      = ($urandom_range(0, 99) < 70);
      r      = ($urandom_range(0, 99) < ((i < 400) ? 25 : 90));
      c      = ($urandom_range(0, 39) == 0);
      rs     = ($urandom_range(0, 249) == 0);
      step(st(v, r, c, rs, w));
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL random_model cycle=%0d got=%h required=%h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; packet_word_valid_i = 1'b0;
    packet_ready_i = 1'b0; packet_word_i = '0;
    m_in_pkt = 0; m_ovf = 0; m_lerr = 0; m_got = 0; m_need = 0; m_len = 0; m_buf = '0;
    test_reset();
    test_single();
    test_multi_word();
    test_len_error();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
